// File: rtl/menu_pkg.sv
// Shared menu/mode definitions used by the mode selector, the display mux and the game cores.
package menu_pkg;

    localparam int STATE_W   = 2;
    localparam int MODE_MENU = 0;

    typedef enum logic [STATE_W-1:0] {
        MENU      = 2'd0,
        SEL_WAIT  = 2'd1,
        ACTIVE    = 2'd2,
        BACK_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/menu_mode_fsm_prio_enc_lsb.sv
// Lowest-set-bit priority encoder: idx is the smallest i with vec[i] set; valid flags any bit set.
module prio_enc_lsb #(
    parameter int N     = 2,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/menu_mode_fsm.sv
// Top-level game mode selector: debounced-by-release select/back handling, start/exit strobes
// and an optional inactivity timeout that returns to the menu.
module menu_mode_fsm
    import menu_pkg::*;
#(
    parameter int NUM_MODES      = 2,
    parameter int MODE_W         = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 iReset,
    input  logic [NUM_MODES-1:0] iSel,
    input  logic                 iBack,
    input  logic                 iActivity,
    output logic [MODE_W-1:0]    oMode,
    output logic                 oModeStart,
    output logic                 oModeExit,
    output logic [STATE_W-1:0]   oState
);

    state_t            state;
    logic [MODE_W-1:0] sel_idx;
    logic [CNT_W-1:0]  counter;
    logic [MODE_W-1:0] enc_idx;
    logic              enc_valid;
    logic              timeout_hit;

    prio_enc_lsb #(
        .N     (NUM_MODES),
        .IDX_W (MODE_W)
    ) u_prio_enc (
        .vec   (iSel),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // An activity pulse in the expiring cycle still rescues the game.
    assign timeout_hit = (TIMEOUT_CYCLES > 0)
                       && (counter == CNT_W'(TIMEOUT_CYCLES - 1))
                       && !iActivity;

    assign oState = state;

    always_ff @(posedge clk) begin
        if (iReset) begin
            state      <= MENU;
            sel_idx    <= '0;
            counter    <= '0;
            oMode      <= MODE_W'(MODE_MENU);
            oModeStart <= 1'b0;
            oModeExit  <= 1'b0;
        end else begin
            oModeStart <= 1'b0;
            oModeExit  <= 1'b0;
            case (state)
                MENU: begin
                    oMode   <= MODE_W'(MODE_MENU);
                    counter <= '0;
                    if (enc_valid) begin
                        sel_idx <= enc_idx;
                        state   <= SEL_WAIT;
                    end else if (iBack) begin
                        state <= BACK_WAIT;
                    end
                end
                SEL_WAIT: begin
                    counter <= '0;
                    // Every select key must be up, not just the chosen one.
                    if (iSel == '0) begin
                        state      <= ACTIVE;
                        oMode      <= sel_idx + MODE_W'(1);
                        oModeStart <= 1'b1;
                    end else begin
                        oMode <= MODE_W'(MODE_MENU);
                    end
                end
                ACTIVE: begin
                    if (iBack) begin
                        state     <= BACK_WAIT;
                        oMode     <= MODE_W'(MODE_MENU);
                        oModeExit <= 1'b1;
                        counter   <= '0;
                    end else if (timeout_hit) begin
                        state     <= MENU;
                        oMode     <= MODE_W'(MODE_MENU);
                        oModeExit <= 1'b1;
                        counter   <= '0;
                    end else begin
                        oMode   <= sel_idx + MODE_W'(1);
                        counter <= iActivity ? '0 : counter + CNT_W'(1);
                    end
                end
                BACK_WAIT: begin
                    oMode   <= MODE_W'(MODE_MENU);
                    counter <= '0;
                    if (!iBack) begin
                        state <= MENU;
                    end
                end
                default: begin
                    state   <= MENU;
                    oMode   <= MODE_W'(MODE_MENU);
                    counter <= '0;
                end
            endcase
        end
    end

endmodule
